// File: rtl/x_rams_pkg.sv
// Shared constants, clear-sequencer state type and clog2 helper for x_rams_param.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package x_rams_pkg;

    localparam int BANK_D  = 16;  // words per storage bank
    localparam int BANK_AW = 4;   // address bits inside one bank

    typedef enum logic {
        IDLE  = 1'b0,
        CLEAR = 1'b1
    } clr_state_e;

    // Minimum number of bits needed to address v entries (v >= 1).
    function automatic int clog2(input int v);
        int r;
        r = 0;
        for (int x = v - 1; x > 0; x = x >> 1) begin
            r++;
        end
        return r;
    endfunction

endpackage

// File: rtl/x_rams_param_if.sv
// Bus bundle for x_rams_param: port A read/write, port B read, clear control.
// Latency: n/a (wiring only).
// Backpressure: BUSY from the RAM tells the master that port A accesses are dropped.
// Ports: WE/ADR/I/RE (port A), O/O_VLD (port A data), DADR/DO (port B), CLR/BUSY (clear).
interface x_rams_param_if #(
    parameter int WIDTH = 8,
    parameter int AW    = 7
);
    logic             WE;
    logic [AW-1:0]    ADR;
    logic [WIDTH-1:0] I;
    logic             RE;
    logic [WIDTH-1:0] O;
    logic             O_VLD;
    logic [AW-1:0]    DADR;
    logic [WIDTH-1:0] DO;
    logic             CLR;
    logic             BUSY;

    // Master drives requests into the RAM.
    modport master (
        output WE, ADR, I, RE, DADR, CLR,
        input  O, O_VLD, DO, BUSY
    );

    // Slave is the RAM itself.
    modport slave (
        input  WE, ADR, I, RE, DADR, CLR,
        output O, O_VLD, DO, BUSY
    );
endinterface

// File: rtl/x_rams_bank.sv
// 16 x WIDTH storage slice: synchronous write, two asynchronous read ports.
// Latency: write lands on the rising edge; reads are combinational.
// Backpressure: none; the write enable is decoded by the parent.
// Ports: clk_i, we_i/wadr_i/wdat_i (write), radr_a_i/rdat_a_o and radr_b_i/rdat_b_o (reads).
module x_rams_bank
    import x_rams_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic               clk_i,
    input  logic               we_i,
    input  logic [BANK_AW-1:0] wadr_i,
    input  logic [WIDTH-1:0]   wdat_i,
    input  logic [BANK_AW-1:0] radr_a_i,
    output logic [WIDTH-1:0]   rdat_a_o,
    input  logic [BANK_AW-1:0] radr_b_i,
    output logic [WIDTH-1:0]   rdat_b_o
);

    // LUT-RAM style storage: deliberately has no reset.
    logic [WIDTH-1:0] mem_q [BANK_D];

    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[wadr_i] <= wdat_i;
        end
    end

    assign rdat_a_o = mem_q[radr_a_i];
    assign rdat_b_o = mem_q[radr_b_i];

endmodule

// File: rtl/x_rams_param.sv
// WIDTH x DEPTH distributed RAM with async port B, optional O register and a clear sequencer.
// Latency: write 1 edge; O 1 cycle after RE (OREG=1) or combinational (OREG=0); DO combinational.
// Backpressure: BUSY high during the DEPTH-cycle clear; port A writes/reads are dropped then.
// Ports: CLK, RST_N (async active-low), bus (x_rams_param_if slave).
module x_rams_param
    import x_rams_pkg::*;
#(
    parameter int               WIDTH    = 8,
    parameter int               DEPTH    = 128,
    parameter int               OREG     = 1,
    parameter logic [WIDTH-1:0] INIT_VAL = '0
) (
    input  logic          CLK,
    input  logic          RST_N,
    x_rams_param_if.slave bus
);

    localparam int AW = clog2(DEPTH);
    localparam int NB = DEPTH / BANK_D;
    // Bank-select width; a single bank still gets a 1-bit select that is always 0.
    localparam int BW = (AW > BANK_AW) ? (AW - BANK_AW) : 1;

    clr_state_e       state_q, state_d;
    logic [AW-1:0]    cnt_q, cnt_d;
    logic             busy;

    logic             wr_en;
    logic [AW-1:0]    wr_adr;
    logic [WIDTH-1:0] wr_dat;
    logic [BW-1:0]    wr_bank;
    logic [BW-1:0]    ra_bank;
    logic [BW-1:0]    rb_bank;

    logic [WIDTH-1:0] rd_a [NB];
    logic [WIDTH-1:0] rd_b [NB];
    logic [WIDTH-1:0] rd_a_mux;

    // ---------------- clear sequencer ----------------
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q <= CLEAR;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            CLEAR: begin
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == AW'(DEPTH - 1)) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end
            end
            IDLE: begin
                if (bus.CLR) begin
                    state_d = CLEAR;
                    cnt_d   = '0;
                end
            end
            default: begin
                state_d = CLEAR;
                cnt_d   = '0;
            end
        endcase
    end

    // BUSY comes straight from the state register: no input-to-BUSY path.
    assign busy     = (state_q == CLEAR);
    assign bus.BUSY = busy;

    // The clear borrows the single bank write port; user writes are dropped meanwhile.
    assign wr_en  = busy | bus.WE;
    assign wr_adr = busy ? cnt_q : bus.ADR;
    assign wr_dat = busy ? INIT_VAL : bus.I;

    // Upper address bits pick the bank, lower four pick the word inside it.
    assign wr_bank = BW'({1'b0, wr_adr}   >> BANK_AW);
    assign ra_bank = BW'({1'b0, bus.ADR}  >> BANK_AW);
    assign rb_bank = BW'({1'b0, bus.DADR} >> BANK_AW);

    for (genvar b = 0; b < NB; b++) begin : g_bank
        x_rams_bank #(.WIDTH(WIDTH)) u_bank (
            .clk_i    (CLK),
            .we_i     (wr_en && (wr_bank == BW'(b))),
            .wadr_i   (wr_adr[BANK_AW-1:0]),
            .wdat_i   (wr_dat),
            .radr_a_i (bus.ADR[BANK_AW-1:0]),
            .rdat_a_o (rd_a[b]),
            .radr_b_i (bus.DADR[BANK_AW-1:0]),
            .rdat_b_o (rd_b[b])
        );
    end

    assign rd_a_mux = rd_a[ra_bank];
    assign bus.DO   = rd_b[rb_bank];

    // ---------------- port A output ----------------
    if (OREG != 0) begin : g_oreg
        logic [WIDTH-1:0] o_q;
        logic             o_vld_q;

        // Sampling the pre-edge mux output makes same-address write+read return the old word.
        always_ff @(posedge CLK or negedge RST_N) begin
            if (!RST_N) begin
                o_q     <= '0;
                o_vld_q <= 1'b0;
            end else begin
                o_vld_q <= bus.RE && !busy;
                if (bus.RE && !busy) begin
                    o_q <= rd_a_mux;
                end
            end
        end

        assign bus.O     = o_q;
        assign bus.O_VLD = o_vld_q;
    end else begin : g_oasync
        logic unused_re;
        assign unused_re = bus.RE;
        assign bus.O     = rd_a_mux;
        assign bus.O_VLD = 1'b1;
    end

endmodule

// File: tb/tb_x_rams_param.sv
// Bench for x_rams_param: 128x8 registered-O instance and 32x4 async-O instance side by side.
// Latency: n/a.
// Backpressure: n/a.
module tb_x_rams_param;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    x_rams_param_if #(.WIDTH(8), .AW(7)) b1 ();
    x_rams_param_if #(.WIDTH(4), .AW(5)) b2 ();

    x_rams_param #(.WIDTH(8), .DEPTH(128), .OREG(1), .INIT_VAL(8'hA5)) u_dut1 (
        .CLK(clk), .RST_N(rst_n), .bus(b1)
    );
    x_rams_param #(.WIDTH(4), .DEPTH(32), .OREG(0), .INIT_VAL(4'h9)) u_dut2 (
        .CLK(clk), .RST_N(rst_n), .bus(b2)
    );

    int total = 0;
    int bad   = 0;
    bit chk_en = 1'b0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // ---------------- behavioural models ----------------
    // Memory as an array with "known" flags; the clear is a countdown of words still to wipe.
    logic [7:0] m1 [128];
    bit         k1 [128];
    int         left1 = 128;
    logic [7:0] mo1 = 8'h00;
    bit         mv1 = 1'b0;

    logic [3:0] m2 [32];
    bit         k2 [32];
    int         left2 = 32;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            left1 = 128;
            mo1   = 8'h00;
            mv1   = 1'b0;
        end else if (left1 > 0) begin
            m1[128 - left1] = 8'hA5;
            k1[128 - left1] = 1'b1;
            left1--;
            mv1 = 1'b0;
        end else begin
            mv1 = 1'b0;
            if (b1.RE) begin
                mo1 = m1[b1.ADR];
                mv1 = 1'b1;
            end
            if (b1.WE) begin
                m1[b1.ADR] = b1.I;
                k1[b1.ADR] = 1'b1;
            end
            if (b1.CLR) left1 = 128;
        end
    end

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            left2 = 32;
        end else if (left2 > 0) begin
            m2[32 - left2] = 4'h9;
            k2[32 - left2] = 1'b1;
            left2--;
        end else begin
            if (b2.WE) begin
                m2[b2.ADR] = b2.I;
                k2[b2.ADR] = 1'b1;
            end
            if (b2.CLR) left2 = 32;
        end
    end

    // Cycle compare, 1 time unit after each rising edge.
    always @(posedge clk) begin
        #1;
        if (chk_en) begin
            chk("m1_busy", 32'(b1.BUSY), 32'(left1 > 0));
            chk("m1_ovld", 32'(b1.O_VLD), 32'(mv1));
            chk("m1_o", 32'(b1.O), 32'(mo1));
            if (k1[b1.DADR]) chk("m1_do", 32'(b1.DO), 32'(m1[b1.DADR]));
            chk("m2_busy", 32'(b2.BUSY), 32'(left2 > 0));
            chk("m2_ovld", 32'(b2.O_VLD), 32'd1);
            if (k2[b2.ADR])  chk("m2_o", 32'(b2.O), 32'(m2[b2.ADR]));
            if (k2[b2.DADR]) chk("m2_do", 32'(b2.DO), 32'(m2[b2.DADR]));
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    // Counts rising edges from now until BUSY on the 128x8 instance drops.
    task automatic count_clear(output int n, input bit poke);
        n = 0;
        while (n < 300) begin
            @(posedge clk);
            n++;
            @(negedge clk);
            if (poke) begin
                // Writes and CLR during the clear must have no effect.
                if (n == 10) begin b1.WE = 1'b1; b1.ADR = 7'h00; b1.I = 8'hFF; end
                if (n == 11) b1.WE = 1'b0;
                if (n == 50) b1.CLR = 1'b1;
                if (n == 51) b1.CLR = 1'b0;
            end
            if (!b1.BUSY) break;
        end
    endtask

    int n;

    initial begin
        b1.WE = 0; b1.ADR = '0; b1.I = '0; b1.RE = 0; b1.DADR = '0; b1.CLR = 0;
        b2.WE = 0; b2.ADR = '0; b2.I = '0; b2.RE = 0; b2.DADR = '0; b2.CLR = 0;
        repeat (2) @(negedge clk);
        chk_en = 1'b1;
        chk("rst_busy1", 32'(b1.BUSY), 32'd1);
        chk("rst_o1", 32'(b1.O), 32'h00);
        chk("rst_ovld1", 32'(b1.O_VLD), 32'd0);
        chk("rst_busy2", 32'(b2.BUSY), 32'd1);

        // Reset release: clear must take exactly 128 edges despite WE/CLR noise.
        rst_n = 1'b1;
        count_clear(n, 1'b1);
        chk("clear_len", 32'(n), 32'd128);
        b1.DADR = 7'd0;   #1 chk("init_do0",   32'(b1.DO), 32'hA5);
        b1.DADR = 7'd63;  #1 chk("init_do63",  32'(b1.DO), 32'hA5);
        b1.DADR = 7'd127; #1 chk("init_do127", 32'(b1.DO), 32'hA5);
        @(negedge clk);

        // Write then registered read.
        b1.WE = 1'b1; b1.ADR = 7'h55; b1.I = 8'h3C; b1.DADR = 7'h55;
        @(negedge clk);
        b1.WE = 1'b0;
        chk("wr_do55", 32'(b1.DO), 32'h3C);
        b1.RE = 1'b1;
        @(negedge clk);
        b1.RE = 1'b0;
        chk("rd_o55", 32'(b1.O), 32'h3C);
        chk("rd_ovld", 32'(b1.O_VLD), 32'd1);
        @(negedge clk);
        chk("hold_ovld", 32'(b1.O_VLD), 32'd0);
        chk("hold_o", 32'(b1.O), 32'h3C);

        // Read-first on same-address write + read.
        b1.WE = 1'b1; b1.ADR = 7'h10; b1.I = 8'h11;
        @(negedge clk);
        b1.RE = 1'b1; b1.I = 8'h22;
        @(negedge clk);
        b1.WE = 1'b0;
        chk("rf_old", 32'(b1.O), 32'h11);
        @(negedge clk);
        b1.RE = 1'b0;
        chk("rf_new", 32'(b1.O), 32'h22);

        // CLR-started clear interrupted by reset at cycle 60.
        b1.CLR = 1'b1;
        @(negedge clk);
        b1.CLR = 1'b0;
        chk("clr_busy", 32'(b1.BUSY), 32'd1);
        repeat (60) @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("mid_o", 32'(b1.O), 32'h00);
        chk("mid_ovld", 32'(b1.O_VLD), 32'd0);
        chk("mid_busy", 32'(b1.BUSY), 32'd1);
        @(negedge clk);
        rst_n = 1'b1;
        count_clear(n, 1'b0);
        chk("reclear_len", 32'(n), 32'd128);
        b1.DADR = 7'h55; #1 chk("reclear_do55", 32'(b1.DO), 32'hA5);
        @(negedge clk);

        // Bank boundary on the 32x4 async instance.
        chk("b2_idle", 32'(b2.BUSY), 32'd0);
        b2.WE = 1'b1; b2.ADR = 5'd15; b2.I = 4'h3;
        @(negedge clk);
        chk("b2_o15_now", 32'(b2.O), 32'h3);
        b2.ADR = 5'd16; b2.I = 4'hC;
        @(negedge clk);
        b2.WE = 1'b0;
        chk("b2_o16_now", 32'(b2.O), 32'hC);
        b2.ADR = 5'd15; b2.DADR = 5'd15; #1;
        chk("b2_o15", 32'(b2.O), 32'h3);
        chk("b2_do15", 32'(b2.DO), 32'h3);
        b2.ADR = 5'd16; b2.DADR = 5'd16; #1;
        chk("b2_o16", 32'(b2.O), 32'hC);
        chk("b2_do16", 32'(b2.DO), 32'hC);
        b2.ADR = 5'd31; b2.DADR = 5'd0; #1;
        chk("b2_o31", 32'(b2.O), 32'h9);
        chk("b2_do0", 32'(b2.DO), 32'h9);
        chk("b2_ovld", 32'(b2.O_VLD), 32'd1);

        repeat (3) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
